// File: rtl/boot_copier.sv
// boot_copier: bus initiator that copies len_words 32-bit words from src_addr
// to dst_addr through a single access/cs/addr/bytesel/ack data port.
// Optional feature macro: BOOT_COPIER_CHECKSUM_EN (running sum of read words on csum).
module boot_copier #(
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          csum,
  output logic                 m_access,
  output logic                 m_cs,
  output logic [31:0]          m_addr,
  output logic [3:0]           m_bytesel,
  output logic                 m_wr_en,
  output logic [31:0]          m_wr_val,
  input  logic [31:0]          m_data,
  input  logic                 m_ack
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t               state_q, state_d;
  logic                 access_q, access_d;
  logic                 error_q, error_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          data_q, data_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] idx_q, idx_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;

  logic                 start_ok;
  logic                 rd_capture;
  logic                 timeout_hit;
  logic                 last_word;
  logic [31:0]          offset;

  assign start_ok    = (state_q == IDLE) && start;
  assign rd_capture  = (state_q == RD) && m_ack && !abort;
  assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign last_word   = ((idx_q + LEN_WIDTH'(1)) == len_q);
  assign offset      = 32'(idx_q) << 2;

  // Next-state and datapath update; abort outranks ack and timeout.
  always_comb begin
    state_d  = state_q;
    access_d = access_q;
    error_d  = error_q;
    src_d    = src_q;
    dst_d    = dst_q;
    data_d   = data_q;
    len_d    = len_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr & 32'hFFFF_FFFC;
          dst_d   = dst_addr & 32'hFFFF_FFFC;
          len_d   = len_words;
          idx_d   = '0;
          wait_d  = '0;
          error_d = 1'b0;
          if (len_words == '0) begin
            state_d = FIN;
          end else begin
            state_d  = RD;
            access_d = 1'b1;
          end
        end
      end
      RD, WR: begin
        if (abort) begin
          state_d  = IDLE;
          access_d = 1'b0;
        end else if (m_ack) begin
          wait_d = '0;
          if (state_q == RD) begin
            data_d   = m_data;
            state_d  = WR;
            access_d = 1'b1;
          end else begin
            idx_d = idx_q + LEN_WIDTH'(1);
            if (last_word) begin
              state_d  = FIN;
              access_d = 1'b0;
            end else begin
              state_d  = RD;
              access_d = 1'b1;
            end
          end
        end else if (timeout_hit) begin
          error_d  = 1'b1;
          access_d = 1'b0;
          state_d  = FIN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      access_q <= 1'b0;
      error_q  <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
      error_q  <= error_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
    end
  end

`ifdef BOOT_COPIER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Checksum accumulates every word captured from a read.
  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (rd_capture) begin
      csum_d = csum_q + m_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

  // Bus and status outputs; the request is masked by ack so a 1-cycle
  // responder never sees a repeated request.
  always_comb begin
    m_access  = access_q & ~m_ack;
    m_cs      = m_access;
    m_bytesel = m_access ? 4'b1111 : 4'b0000;
    m_wr_en   = m_access && (state_q == WR);
    m_addr    = '0;
    m_wr_val  = '0;
    if (state_q == RD) begin
      m_addr = src_q + offset;
    end else if (state_q == WR) begin
      m_addr   = dst_q + offset;
      m_wr_val = data_q;
    end
    busy  = (state_q != IDLE);
    done  = (state_q == FIN) && !abort;
    error = error_q;
  end

endmodule
